// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared I2S types and constants for the RX and TX stages
package i2s_pkg;

    localparam int I2S_DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {SYNC, LEFT, RIGHT} i2s_rx_state_t;

endpackage

// File: rtl/i2s_rx_deser.sv
// rtl/i2s_rx_deser.sv - one channel's left-justified shift register with saturating bit counter
module i2s_rx_deser
    import i2s_pkg::*;
#(
    parameter int WIDTH = I2S_DEFAULT_WIDTH
) (
    input  logic             sclk,
    input  logic             rst,
    input  logic             shift_en,
    input  logic             clear,
    input  logic             sdata,
    output logic [WIDTH-1:0] word
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_next;
    logic [CW-1:0]    cnt;
    logic             take;

    // Bits beyond WIDTH in a long slot are dropped once the counter saturates.
    assign take = shift_en && (cnt < CW'(WIDTH));

    // Bits land MSB-first at a fixed position so a short slot leaves zeros in the LSBs.
    always_comb begin
        sr_next = sr;
        for (int i = 0; i < WIDTH; i++) begin
            if (take && (cnt == CW'(WIDTH - 1 - i))) begin
                sr_next[i] = sdata;
            end
        end
    end

    // The word includes the bit captured this cycle, so the edge cycle can hand it off directly.
    assign word = sr_next;

    // Clear happens as the channel's slot starts; the word then holds until the next start.
    always_ff @(posedge sclk) begin
        if (rst || clear) begin
            sr  <= '0;
            cnt <= '0;
        end else if (take) begin
            sr  <= sr_next;
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/i2s_rx.sv
// rtl/i2s_rx.sv - I2S receiver: lrclk framing, stereo output register, valid/ready and overrun
module i2s_rx
    import i2s_pkg::*;
#(
    parameter int WIDTH = I2S_DEFAULT_WIDTH
) (
    input  logic             sclk,
    input  logic             rst,
    input  logic             lrclk,
    input  logic             sdata,
    output logic [WIDTH-1:0] left_out,
    output logic [WIDTH-1:0] right_out,
    output logic             valid,
    input  logic             ready,
    output logic             overrun,
    input  logic             overrun_clr
);

    i2s_rx_state_t    state;
    logic             lrclk_q;
    logic             lr_seen;
    logic             lr_edge;
    logic             rise;
    logic             fall;
    logic             frame_done;
    logic             drop;
    logic [WIDTH-1:0] left_word;
    logic [WIDTH-1:0] right_word;

    // lrclk_q powers up as 1; an edge only counts once a real lrclk sample has been taken,
    // so coming out of reset inside a left slot does not fake a falling edge.
    assign lr_edge    = lr_seen && (lrclk != lrclk_q);
    assign rise       = lr_edge && lrclk;
    assign fall       = lr_edge && !lrclk;
    assign frame_done = (state == RIGHT) && fall;
    assign drop       = frame_done && valid && !ready;

    // Register word select for edge detection.
    always_ff @(posedge sclk) begin
        if (rst) begin
            lrclk_q <= 1'b1;
            lr_seen <= 1'b0;
        end else begin
            lrclk_q <= lrclk;
            lr_seen <= 1'b1;
        end
    end

    // The active channel follows lrclk_q, so the edge cycle still feeds the ending channel.
    i2s_rx_deser #(.WIDTH(WIDTH)) u_left (
        .sclk     (sclk),
        .rst      (rst),
        .shift_en (!lrclk_q),
        .clear    (fall),
        .sdata    (sdata),
        .word     (left_word)
    );

    i2s_rx_deser #(.WIDTH(WIDTH)) u_right (
        .sclk     (sclk),
        .rst      (rst),
        .shift_en (lrclk_q),
        .clear    (rise),
        .sdata    (sdata),
        .word     (right_word)
    );

    // Frame FSM plus output register, handshake and sticky overrun.
    always_ff @(posedge sclk) begin
        if (rst) begin
            state     <= SYNC;
            valid     <= 1'b0;
            left_out  <= '0;
            right_out <= '0;
            overrun   <= 1'b0;
        end else begin
            case (state)
                SYNC:    if (fall) state <= LEFT;
                LEFT:    if (rise) state <= RIGHT;
                RIGHT:   if (fall) state <= LEFT;
                default: state <= SYNC;
            endcase

            if (frame_done) begin
                if (!valid || ready) begin
                    left_out  <= left_word;
                    right_out <= right_word;
                    valid     <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end

            if (drop) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule
